// File: rtl/secuenciador_pkg.sv
// Shared types and command helpers for the tracker axis motor sequencer.
package secuenciador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_THETA,
        ST_SETTLE_THETA,
        ST_MOVE_PHI,
        ST_SETTLE_PHI,
        ST_FAULT
    } estado_e;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_CW   = 2'b01;
    localparam logic [1:0] CMD_CCW  = 2'b11;

    // 2'b10 is reserved and behaves like stop.
    function automatic logic cmd_valid(input logic [1:0] cmd);
        return (cmd == CMD_CW) || (cmd == CMD_CCW);
    endfunction

    function automatic logic [1:0] cmd_de_dir(input logic dir);
        return dir ? CMD_CCW : CMD_CW;
    endfunction

    function automatic logic cmd_es_parada(input logic [1:0] cmd);
        return (cmd == CMD_STOP) || !cmd_valid(cmd);
    endfunction

endpackage

// File: rtl/generador_pasos.sv
// Step-rate divider with a saturating step counter and runaway-move flag.
// One instance is time-shared by both axes; the caller routes the pulse.
module generador_pasos #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STEP_DIV      = 5000,
    parameter int unsigned TIMEOUT_STEPS = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic paso,
    output logic timeout
);

    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_STEPS);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        paso  = 1'b0;
        if (clr) begin
            div_d = '0;
            cnt_d = '0;
        end else if (en) begin
            if (div_q >= DIV_LAST) begin
                div_d = '0;
                paso  = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                div_d = div_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q >= TIMEOUT_LIM);

endmodule

// File: rtl/secuenciador_motores.sv
// Alternating theta/phi step sequencer with settle dwell and runaway fault.
// Define CONTADOR_PASOS_EN to add signed per-axis position counters.
//
// state        | meaning
// ST_IDLE      | no axis driven, waiting for a valid command
// ST_MOVE_*    | stepping the axis at the divided rate
// ST_SETTLE_*  | post-move dwell, then pick next axis round-robin
// ST_FAULT     | runaway move detected, waits for clr_fault
module secuenciador_motores
    import secuenciador_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STEP_DIV      = 5000,
    parameter int unsigned SETTLE_CYC    = 50000,
    parameter int unsigned TIMEOUT_STEPS = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       habilitar,
    input  logic [1:0] cmd_theta,
    input  logic [1:0] cmd_phi,
    input  logic       clr_fault,
    output logic       step_theta,
    output logic       dir_theta,
    output logic       step_phi,
    output logic       dir_phi,
    output logic       eje_activo,
    output logic       busy,
    output logic       fault
`ifdef CONTADOR_PASOS_EN
    ,
    output logic signed [CNT_W-1:0] pos_theta,
    output logic signed [CNT_W-1:0] pos_phi
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    estado_e          state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             dir_theta_q, dir_theta_d;
    logic             dir_phi_q, dir_phi_d;
    logic             eje_q, eje_d;
    logic             step_theta_q, step_theta_d;
    logic             step_phi_q, step_phi_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic             gen_clr;
    logic             gen_en;
    logic             gen_paso;
    logic             gen_timeout;

    generador_pasos #(
        .CNT_W         (CNT_W),
        .STEP_DIV      (STEP_DIV),
        .TIMEOUT_STEPS (TIMEOUT_STEPS)
    ) u_generador_pasos (
        .clk     (clk),
        .rst     (rst),
        .clr     (gen_clr),
        .en      (gen_en),
        .paso    (gen_paso),
        .timeout (gen_timeout)
    );

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        dir_theta_d = dir_theta_q;
        dir_phi_d   = dir_phi_q;
        eje_d       = eje_q;

        case (state_q)
            ST_IDLE: begin
                if (habilitar && cmd_valid(cmd_theta)) begin
                    state_d = ST_MOVE_THETA;
                end else if (habilitar && cmd_valid(cmd_phi)) begin
                    state_d = ST_MOVE_PHI;
                end
            end
            ST_MOVE_THETA: begin
                if (gen_timeout) begin
                    state_d = ST_FAULT;
                end else if (!habilitar || cmd_es_parada(cmd_theta) ||
                             (cmd_theta != cmd_de_dir(dir_theta_q))) begin
                    state_d = ST_SETTLE_THETA;
                end
            end
            ST_MOVE_PHI: begin
                if (gen_timeout) begin
                    state_d = ST_FAULT;
                end else if (!habilitar || cmd_es_parada(cmd_phi) ||
                             (cmd_phi != cmd_de_dir(dir_phi_q))) begin
                    state_d = ST_SETTLE_PHI;
                end
            end
            ST_SETTLE_THETA: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CNT_W'(1);
                end else if (!habilitar) begin
                    state_d = ST_IDLE;
                end else if (cmd_valid(cmd_phi)) begin
                    state_d = ST_MOVE_PHI;
                end else if (cmd_valid(cmd_theta)) begin
                    state_d = ST_MOVE_THETA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE_PHI: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CNT_W'(1);
                end else if (!habilitar) begin
                    state_d = ST_IDLE;
                end else if (cmd_valid(cmd_theta)) begin
                    state_d = ST_MOVE_THETA;
                end else if (cmd_valid(cmd_phi)) begin
                    state_d = ST_MOVE_PHI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entry actions: direction and axis ownership are captured only here.
        if (state_d != state_q) begin
            case (state_d)
                ST_MOVE_THETA: begin
                    dir_theta_d = (cmd_theta == CMD_CCW);
                    eje_d       = 1'b0;
                end
                ST_MOVE_PHI: begin
                    dir_phi_d = (cmd_phi == CMD_CCW);
                    eje_d     = 1'b1;
                end
                ST_SETTLE_THETA, ST_SETTLE_PHI: settle_d = SETTLE_LAST;
                default: settle_d = '0;
            endcase
        end
    end

    // Stepping only continues while the axis stays in MOVE, so a pulse never
    // lands in the first SETTLE or FAULT cycle.
    always_comb begin
        gen_clr      = (state_d != state_q);
        gen_en       = ((state_q == ST_MOVE_THETA) || (state_q == ST_MOVE_PHI)) &&
                       (state_d == state_q);
        step_theta_d = gen_paso && (state_q == ST_MOVE_THETA);
        step_phi_d   = gen_paso && (state_q == ST_MOVE_PHI);
        busy_d       = (state_d != ST_IDLE);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            dir_theta_q  <= 1'b0;
            dir_phi_q    <= 1'b0;
            eje_q        <= 1'b0;
            step_theta_q <= 1'b0;
            step_phi_q   <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            dir_theta_q  <= dir_theta_d;
            dir_phi_q    <= dir_phi_d;
            eje_q        <= eje_d;
            step_theta_q <= step_theta_d;
            step_phi_q   <= step_phi_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign step_theta = step_theta_q;
    assign dir_theta  = dir_theta_q;
    assign step_phi   = step_phi_q;
    assign dir_phi    = dir_phi_q;
    assign eje_activo = eje_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

`ifdef CONTADOR_PASOS_EN
    logic signed [CNT_W-1:0] pos_theta_q, pos_theta_d;
    logic signed [CNT_W-1:0] pos_phi_q, pos_phi_d;

    always_comb begin
        pos_theta_d = pos_theta_q;
        pos_phi_d   = pos_phi_q;
        if (step_theta_d) begin
            pos_theta_d = dir_theta_q ? (pos_theta_q - CNT_W'(1)) : (pos_theta_q + CNT_W'(1));
        end
        if (step_phi_d) begin
            pos_phi_d = dir_phi_q ? (pos_phi_q - CNT_W'(1)) : (pos_phi_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_theta_q <= '0;
            pos_phi_q   <= '0;
        end else begin
            pos_theta_q <= pos_theta_d;
            pos_phi_q   <= pos_phi_d;
        end
    end

    assign pos_theta = pos_theta_q;
    assign pos_phi   = pos_phi_q;
`endif

endmodule

// File: tb/tb_secuenciador_motores.sv
// Directed and random bench for secuenciador_motores against a behavioural model.
module tb_secuenciador_motores;

    localparam int CNT_W         = 16;
    localparam int STEP_DIV      = 4;
    localparam int SETTLE_CYC    = 3;
    localparam int TIMEOUT_STEPS = 5;

    localparam int M_IDLE   = 0;
    localparam int M_MOVE   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_FAULT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       habilitar = 1'b0;
    logic [1:0] cmd_theta = 2'b00;
    logic [1:0] cmd_phi = 2'b00;
    logic       clr_fault = 1'b0;
    logic       step_theta, dir_theta, step_phi, dir_phi, eje_activo, busy, fault;
`ifdef CONTADOR_PASOS_EN
    logic signed [CNT_W-1:0] pos_theta, pos_phi;
`endif

    secuenciador_motores #(
        .CNT_W         (CNT_W),
        .STEP_DIV      (STEP_DIV),
        .SETTLE_CYC    (SETTLE_CYC),
        .TIMEOUT_STEPS (TIMEOUT_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .habilitar  (habilitar),
        .cmd_theta  (cmd_theta),
        .cmd_phi    (cmd_phi),
        .clr_fault  (clr_fault),
        .step_theta (step_theta),
        .dir_theta  (dir_theta),
        .step_phi   (step_phi),
        .dir_phi    (dir_phi),
        .eje_activo (eje_activo),
        .busy       (busy),
        .fault      (fault)
`ifdef CONTADOR_PASOS_EN
        ,
        .pos_theta  (pos_theta),
        .pos_phi    (pos_phi)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_theta = 0;
    int pulses_phi = 0;

    // Model: mode, owning axis, cycles since move start, steps taken, dwell left.
    int       m_mode, m_axis, m_age, m_steps, m_left;
    bit [1:0] m_dir;
    bit [1:0] e_step;
    int       m_pos [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit valid(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b11);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_axis = 0; m_age = 0; m_steps = 0; m_left = 0;
        m_dir = 2'b00; e_step = 2'b00;
        m_pos[0] = 0; m_pos[1] = 0;
    endtask

    task automatic model_enter(input int a, input logic [1:0] c);
        m_mode = M_MOVE;
        m_axis = a;
        m_dir[a] = (c == 2'b11);
        m_age = 0;
        m_steps = 0;
    endtask

    task automatic model_step();
        logic [1:0] cur, want, oc;
        int other;
        e_step = 2'b00;
        case (m_mode)
            M_IDLE: begin
                if (habilitar && valid(cmd_theta)) model_enter(0, cmd_theta);
                else if (habilitar && valid(cmd_phi)) model_enter(1, cmd_phi);
            end
            M_MOVE: begin
                cur  = (m_axis == 1) ? cmd_phi : cmd_theta;
                want = m_dir[m_axis] ? 2'b11 : 2'b01;
                if (m_steps >= TIMEOUT_STEPS) begin
                    m_mode = M_FAULT;
                end else if (!habilitar || cur != want) begin
                    m_mode = M_SETTLE;
                    m_left = SETTLE_CYC;
                end else begin
                    m_age++;
                    if (m_age % STEP_DIV == 0) begin
                        e_step[m_axis] = 1'b1;
                        m_steps++;
                        m_pos[m_axis] += m_dir[m_axis] ? -1 : 1;
                    end
                end
            end
            M_SETTLE: begin
                if (m_left > 1) begin
                    m_left--;
                end else if (!habilitar) begin
                    m_mode = M_IDLE;
                end else begin
                    other = 1 - m_axis;
                    oc  = (other == 1) ? cmd_phi : cmd_theta;
                    cur = (m_axis == 1) ? cmd_phi : cmd_theta;
                    if (valid(oc)) model_enter(other, oc);
                    else if (valid(cur)) model_enter(m_axis, cur);
                    else m_mode = M_IDLE;
                end
            end
            default: begin
                if (clr_fault) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk(tag, {25'd0, step_theta, step_phi, dir_theta, dir_phi, eje_activo, busy, fault},
                 {25'd0, e_step[0], e_step[1], m_dir[0], m_dir[1], (m_axis == 1),
                  (m_mode != M_IDLE), (m_mode == M_FAULT)});
`ifdef CONTADOR_PASOS_EN
        chk({tag, "_pos_theta"}, 32'(pos_theta), 32'(CNT_W'(m_pos[0])));
        chk({tag, "_pos_phi"}, 32'(pos_phi), 32'(CNT_W'(m_pos[1])));
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (step_theta) pulses_theta++;
        if (step_phi) pulses_phi++;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Single theta move: three pulses, settle, back to idle.
        habilitar = 1'b1; cmd_theta = 2'b01; pulses_theta = 0;
        run(13, "theta_cw");
        chk("theta_cw_pulses", pulses_theta, 3);
        cmd_theta = 2'b00;
        run(5, "theta_stop");
        chk("theta_stop_idle", busy, 0);

        // Simultaneous request: theta first, then phi after settle.
        cmd_theta = 2'b01; cmd_phi = 2'b11;
        run(9, "both_theta");
        chk("both_theta_eje", eje_activo, 0);
        cmd_theta = 2'b00;
        run(4, "both_settle");
        chk("both_phi_eje", eje_activo, 1);
        chk("both_phi_dir", dir_phi, 1);
        cmd_phi = 2'b00;
        run(6, "both_stop");

        // Runaway phi move ends in fault after exactly TIMEOUT_STEPS pulses.
        cmd_phi = 2'b01; pulses_phi = 0;
        run(40, "timeout");
        chk("timeout_pulses", pulses_phi, TIMEOUT_STEPS);
        chk("timeout_fault", fault, 1);
        cmd_phi = 2'b00; clr_fault = 1'b1;
        run(1, "clr_fault");
        clr_fault = 1'b0;
        chk("clr_fault_fault", fault, 0);
        chk("clr_fault_busy", busy, 0);

        // Direction reversal mid-move passes through settle.
        cmd_theta = 2'b01;
        run(6, "rev_cw");
        cmd_theta = 2'b11; pulses_theta = 0;
        run(4, "rev_settle");
        chk("rev_settle_pulses", pulses_theta, 0);
        chk("rev_dir", dir_theta, 1);
        run(4, "rev_ccw");
        chk("rev_ccw_pulses", pulses_theta, 1);
        cmd_theta = 2'b00;
        run(6, "rev_stop");

        // Disable during phi move: settle then idle despite valid command.
        cmd_phi = 2'b01;
        run(3, "dis_move");
        habilitar = 1'b0;
        run(4, "dis_settle");
        chk("dis_idle", busy, 0);
        run(3, "dis_hold");
        cmd_phi = 2'b00; habilitar = 1'b1;

        // Asynchronous reset in the middle of a theta move.
        cmd_theta = 2'b01;
        run(6, "arst_move");
        #3 rst = 1'b1;
        #1;
        chk("arst_outputs", {25'd0, step_theta, step_phi, dir_theta, dir_phi, eje_activo, busy, fault}, 0);
        model_reset();
        rst = 1'b0;
        cmd_theta = 2'b00;
        run(2, "arst_after");
        chk("arst_after_busy", busy, 0);

        // Random command segments.
        for (int s = 0; s < 150; s++) begin
            cmd_theta = 2'($urandom_range(0, 3));
            cmd_phi   = 2'($urandom_range(0, 3));
            habilitar = ($urandom_range(0, 7) != 0);
            clr_fault = ($urandom_range(0, 3) == 0);
            run(int'($urandom_range(1, 25)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_motores.md
Name: secuenciador_motores

Overview:
- Sequences the two tracker axis motors (theta vertical, phi horizontal) from 2-bit direction commands produced by the movement controller.
- Only one axis is driven at a time. Theta/phi are served alternately with a settle dwell between moves.
- Converts each command into step/direction pulses and faults on runaway moves.
- Sits between the movement controller and the motor driver pins.

Parameters:
- CNT_W, 16, width of all internal counters.
- STEP_DIV, 5000, clk cycles per step pulse (range 2..2^CNT_W-1).
- SETTLE_CYC, 50000, dwell cycles after a move before the next axis may start (≥1).
- TIMEOUT_STEPS, 400, steps in one continuous move that trigger FAULT (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- habilitar  in  1  sequencer enable.
- cmd_theta  in  2  theta command: 00 stop, 01 clockwise, 11 counter-clockwise, 10 treated as stop.
- cmd_phi  in  2  phi command, same encoding.
- clr_fault  in  1  clears FAULT.
- step_theta  out  1  one-cycle step pulse, theta.
- dir_theta  out  1  theta direction: 0 cw, 1 ccw.
- step_phi  out  1  one-cycle step pulse, phi.
- dir_phi  out  1  phi direction.
- eje_activo  out  1  0 = theta owns the driver, 1 = phi.
- busy  out  1  state != IDLE.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all counters = 0.
  - All outputs = 0.
- Outputs: all registered. Step pulses are high for exactly one cycle. dir_* hold their last value outside MOVE.
- States: IDLE, MOVE_THETA, SETTLE_THETA, MOVE_PHI, SETTLE_PHI, FAULT.
- IDLE:
  - If habilitar and cmd_theta is valid (01/11): go to MOVE_THETA next cycle.
  - Else if habilitar and cmd_phi is valid: go to MOVE_PHI.
  - Theta wins a simultaneous request from IDLE.
- On entry to MOVE_x:
  - dir_x latched from cmd (01→0, 11→1).
  - Divider and step count cleared.
  - eje_activo updated in the same cycle.
- MOVE_x stepping:
  - Divider counts 0..STEP_DIV-1. In the cycle the divider equals STEP_DIV-1, step_x = 1, the divider wraps to 0 and the step count increments.
  - First pulse occurs STEP_DIV cycles after entry.
- MOVE_x exits (priority order):
  - Step count reaches TIMEOUT_STEPS → FAULT. The pulse that reaches the limit is still emitted.
  - Command becomes stop/10, command reverses direction, or habilitar = 0 → SETTLE_x.
  - A direction reversal never produces a pulse with the new direction without passing through SETTLE.
- SETTLE_x:
  - Holds SETTLE_CYC cycles with no pulses.
  - Then, if habilitar = 0 → IDLE.
  - Else the other axis is served first if its command is valid; else the same axis if valid; else IDLE. This gives round-robin fairness.
- FAULT:
  - No step pulses; fault = 1.
  - clr_fault = 1 → IDLE next cycle, fault = 0.
  - habilitar is ignored in FAULT.
- Command inputs are sampled every cycle. No synchronizer: the commands come from the same clock domain.
- Counters saturate, never wrap past their maximum.

Optional Feature:
- Macro CONTADOR_PASOS_EN.
- When defined: adds outputs pos_theta and pos_phi, each a signed CNT_W-bit position.
  - Each step pulse adds +1 (cw) or −1 (ccw) to its axis, wrapping two's-complement.
  - Both reset to 0 on rst; unaffected by FAULT.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package secuenciador_pkg holds:
  - the state enum;
  - CMD_STOP = 2'b00, CMD_CW = 2'b01, CMD_CCW = 2'b11;
  - a function cmd_valid(cmd).
- One sub-module, generador_pasos: divider, step counter and timeout flag, with clear/enable inputs.
  - A single instance is shared by both axes, since only one axis moves at a time.
  - Its pulse is routed by eje_activo.

Test Plan (STEP_DIV=4, SETTLE_CYC=3, TIMEOUT_STEPS=5):
- Reset mid-MOVE_THETA: rst pulsed async → all outputs 0, busy 0 immediately, state IDLE after release.
- cmd_theta=01 held, cmd_phi=00: MOVE_THETA one cycle after request, dir_theta=0, step_theta pulses every 4 cycles. Drop to 00 after 3 pulses → SETTLE 3 cycles → IDLE.
- cmd_theta=01 and cmd_phi=11 both held from IDLE: theta moves first. Drop cmd_theta after 2 steps → settle, then MOVE_PHI with dir_phi=1, eje_activo=1.
- cmd_phi=01 held 40 cycles: exactly 5 step_phi pulses, then fault=1, no more pulses. clr_fault → IDLE, fault=0.
- cmd_theta switches 01→11 mid-move: SETTLE_THETA 3 cycles with no pulses, re-enter MOVE_THETA with dir_theta=1.
- habilitar=0 during MOVE_PHI: SETTLE_PHI then IDLE, even with cmd_phi still valid.
